flag_unit: RTL and testbench

- Receiving end of the ALU flag outputs. Holds the architectural flags CSR (Sign/Zero/Carry/Overflow).
- Commits ALU-produced next flags, accepts software CSR writes, and keeps a LIFO shadow stack so flags are saved on interrupt entry and restored on return.
- Evaluates branch condition codes against the committed flags for the fetch/branch logic.

---
 rtl/flag_unit.sv | 156 +++++++++++++++
 tb/tb_flag_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - architectural flags CSR with LIFO shadow stack and branch condition evaluation
//
// Holds the committed Sign/Zero/Carry/Overflow flags. The ALU commits flags,
// software can overwrite them, and a shadow stack saves them on interrupt
// entry and restores them on return. cond_true evaluates a branch condition
// code against the committed flags.
//
// Flag bit layout everywhere: [0]=Zero [1]=Carry [2]=Sign [3]=Overflow
//
// Ports:
//   clk          core clock, all state changes on the rising edge
//   rst          synchronous reset, active-high
//   alu_flags    next flags from the ALU
//   flags_we     commit alu_flags this cycle
//   csr_we       software write of the flags CSR
//   csr_wdata    CSR write data, bits [3:0] used
//   csr_rdata    {12'h000, flags}
//   save         push current flags (interrupt entry)
//   restore      pop top slot into flags (interrupt return)
//   cond         condition code to evaluate
//   cond_true    condition result from the registered flags
//   flags        committed flags
//   depth        shadow stack occupancy
//   stack_full   depth == SHADOW_DEPTH
//   stack_empty  depth == 0
//   stack_err    sticky overflow/underflow/conflict indicator
module flag_unit #(
    parameter int SHADOW_DEPTH = 4,
    parameter int DEPTH_W      = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         alu_flags,
    input  logic               flags_we,
    input  logic               csr_we,
    input  logic [15:0]        csr_wdata,
    output logic [15:0]        csr_rdata,
    input  logic               save,
    input  logic               restore,
    input  logic [2:0]         cond,
    output logic               cond_true,
    output logic [3:0]         flags,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_full,
    output logic               stack_empty,
    output logic               stack_err
);

    localparam logic [DEPTH_W-1:0] FULL_LVL = DEPTH_W'(SHADOW_DEPTH);

    logic [3:0]         flags_q, flags_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [3:0]         slot_q [SHADOW_DEPTH];

    logic               full_w;
    logic               empty_w;
    logic [3:0]         top_flags;
    logic               push_ok;
    logic               pop_ok;
    logic               swap_ok;
    logic               err_set;

    // CSR upper bits carry no state
    logic               unused_wdata;
    assign unused_wdata = ^csr_wdata[15:4];

    assign full_w  = (depth_q == FULL_LVL);
    assign empty_w = (depth_q == '0);

    // Top-of-stack is slot[depth-1]; reads as zero when the stack is empty.
    always_comb begin
        top_flags = 4'h0;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (DEPTH_W'(i + 1) == depth_q) begin
                top_flags = slot_q[i];
            end
        end
    end

    // save+restore on a non-empty stack is an in-place swap of the top slot.
    // Any restore on an empty stack is an error regardless of save.
    assign push_ok = save && !restore && !full_w;
    assign pop_ok  = restore && !save && !empty_w;
    assign swap_ok = save && restore && !empty_w;
    assign err_set = (save && !restore && full_w) || (restore && empty_w);

    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        err_d   = err_q | err_set;

        // A successful restore (pop or swap) takes the flags and discards
        // software/ALU writes of the same cycle.
        if (pop_ok || swap_ok) begin
            flags_d = top_flags;
        end else if (csr_we) begin
            flags_d = csr_wdata[3:0];
        end else if (flags_we) begin
            flags_d = alu_flags;
        end

        if (push_ok) begin
            depth_d = depth_q + 1'b1;
        end else if (pop_ok) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'h0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Slot contents are don't-care after reset, so they carry no reset term.
    // Both push and swap store the pre-update flags of this cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (!rst && ((push_ok && DEPTH_W'(i) == depth_q) ||
                         (swap_ok && DEPTH_W'(i + 1) == depth_q))) begin
                slot_q[i] <= flags_q;
            end
        end
    end

    // Condition evaluation sees only registered flags: no same-cycle bypass.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags_q[0];
            3'b010:  cond_true = !flags_q[0];
            3'b011:  cond_true = flags_q[1];
            3'b100:  cond_true = !flags_q[1];
            3'b101:  cond_true = flags_q[2] ^ flags_q[3];
            3'b110:  cond_true = !(flags_q[2] ^ flags_q[3]) && !flags_q[0];
            3'b111:  cond_true = flags_q[1] || flags_q[0];
            default: cond_true = 1'b0;
        endcase
    end

    assign flags       = flags_q;
    assign csr_rdata   = {12'h000, flags_q};
    assign depth       = depth_q;
    assign stack_full  = full_w;
    assign stack_empty = empty_w;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - randomized and directed self-checking bench for flag_unit
module tb_flag_unit;

    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    alu_flags;
    logic          flags_we;
    logic          csr_we;
    logic [15:0]   csr_wdata;
    logic [15:0]   csr_rdata;
    logic          save;
    logic          restore;
    logic [2:0]    cond;
    logic          cond_true;
    logic [3:0]    flags;
    logic [DW-1:0] depth;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: flag nibble, stack as a queue (back = top), sticky error
    logic [3:0] m_flags;
    logic [3:0] m_stack [$];
    logic       m_err;

    flag_unit #(.SHADOW_DEPTH(SD)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_flags   (alu_flags),
        .flags_we    (flags_we),
        .csr_we      (csr_we),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .save        (save),
        .restore     (restore),
        .cond        (cond),
        .cond_true   (cond_true),
        .flags       (flags),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic model_cond(input logic [3:0] f, input logic [2:0] c);
        bit z = f[0];
        bit cy = f[1];
        bit s = f[2];
        bit o = f[3];
        bit signed_less = (s != o);
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return signed_less;
            3'd6: return !signed_less && !z;
            default: return cy || z;
        endcase
    endfunction

    task automatic check_state();
        check("flags", {12'h0, flags}, {12'h0, m_flags});
        check("csr_rdata", csr_rdata, {12'h0, m_flags});
        check("depth", 16'(depth), 16'(m_stack.size()));
        check("full", {15'h0, stack_full}, {15'h0, m_stack.size() == SD});
        check("empty", {15'h0, stack_empty}, {15'h0, m_stack.size() == 0});
        check("err", {15'h0, stack_err}, {15'h0, m_err});
    endtask

    // One clock cycle: drive inputs, check the combinational condition against
    // the pre-edge flags, advance the model across the edge, then check state.
    task automatic cyc(input logic r, input logic sv, input logic rs,
                       input logic fwe, input logic [3:0] af,
                       input logic cwe, input logic [15:0] wd,
                       input logic [2:0] cd);
        bit applied_writes;
        logic [3:0] tmp;
        rst = r; save = sv; restore = rs; flags_we = fwe; alu_flags = af;
        csr_we = cwe; csr_wdata = wd; cond = cd;
        #1;
        check("cond_true", {15'h0, cond_true}, {15'h0, model_cond(m_flags, cd)});
        @(posedge clk);
        if (r) begin
            m_flags = 4'h0;
            m_stack.delete();
            m_err = 1'b0;
        end else begin
            applied_writes = 1;
            if (rs && m_stack.size() == 0) begin
                m_err = 1'b1;
            end else if (rs && sv) begin
                tmp = m_stack[m_stack.size() - 1];
                m_stack[m_stack.size() - 1] = m_flags;
                m_flags = tmp;
                applied_writes = 0;
            end else if (rs) begin
                m_flags = m_stack.pop_back();
                applied_writes = 0;
            end else if (sv) begin
                if (m_stack.size() == SD) m_err = 1'b1;
                else m_stack.push_back(m_flags);
            end
            if (applied_writes) begin
                if (cwe) m_flags = wd[3:0];
                else if (fwe) m_flags = af;
            end
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic probe(input string tag, input logic [2:0] cd, input logic exp);
        cond = cd;
        #1;
        check(tag, {15'h0, cond_true}, {15'h0, exp});
    endtask

    task automatic csr_set(input logic [3:0] v);
        cyc(0, 0, 0, 0, 4'h0, 1, {12'h000, v}, 3'd0);
    endtask

    initial begin
        m_flags = 4'h0;
        m_err = 1'b0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 4'h0, 0, 16'h0, 3'd0);
        check("rst_rdata", csr_rdata, 16'h0000);
        check("rst_empty", {15'h0, stack_empty}, 16'h0001);

        // ALU commit of Zero
        cyc(0, 0, 0, 1, 4'b0001, 0, 16'h0, 3'd1);
        check("z_rdata", csr_rdata, 16'h0001);
        probe("cond_z", 3'b001, 1'b1);
        probe("cond_nz", 3'b010, 1'b0);

        // CSR write wins over ALU commit, upper bits ignored
        cyc(0, 0, 0, 1, 4'h1, 1, 16'hFFF6, 3'd3);
        check("csr_prio", {12'h0, flags}, 16'h0006);
        probe("cond_c", 3'b011, 1'b1);
        probe("cond_be", 3'b111, 1'b1);

        // Signed comparisons
        csr_set(4'h4);
        probe("cond_lt_s", 3'b101, 1'b1);
        probe("cond_gt_s", 3'b110, 1'b0);
        csr_set(4'h0);
        probe("cond_gt_0", 3'b110, 1'b1);
        probe("cond_lt_0", 3'b101, 1'b0);

        // Fill, overflow, drain, underflow
        for (int v = 1; v <= 4; v++) begin
            csr_set(4'(v));
            cyc(0, 1, 0, 0, 4'h0, 0, 16'h0, 3'd0);
        end
        check("fill_full", {15'h0, stack_full}, 16'h0001);
        cyc(0, 1, 0, 0, 4'h0, 0, 16'h0, 3'd0);
        check("ovf_err", {15'h0, stack_err}, 16'h0001);
        check("ovf_depth", 16'(depth), 16'd4);
        for (int v = 4; v >= 1; v--) begin
            cyc(0, 0, 1, 0, 4'h0, 0, 16'h0, 3'd0);
            check("pop_val", {12'h0, flags}, 16'(v));
        end
        cyc(0, 0, 1, 0, 4'h0, 0, 16'h0, 3'd0);
        check("udf_flags", {12'h0, flags}, 16'h0001);
        check("udf_err", {15'h0, stack_err}, 16'h0001);

        // Save alongside ALU commit, restore discards CSR write
        cyc(1, 0, 0, 0, 4'h0, 0, 16'h0, 3'd0);
        csr_set(4'h2);
        cyc(0, 1, 0, 1, 4'h8, 0, 16'h0, 3'd0);
        check("save_we", {12'h0, flags}, 16'h0008);
        cyc(0, 0, 1, 0, 4'h0, 1, 16'h000F, 3'd0);
        check("rest_csr", {12'h0, flags}, 16'h0002);
        check("rest_depth", 16'(depth), 16'd0);

        // Swap, then reset in the middle of activity
        cyc(0, 0, 1, 0, 4'h0, 0, 16'h0, 3'd0);
        csr_set(4'hA);
        cyc(0, 1, 0, 0, 4'h0, 0, 16'h0, 3'd0);
        csr_set(4'h5);
        cyc(0, 1, 1, 1, 4'h3, 1, 16'h0007, 3'd0);
        check("swap_flags", {12'h0, flags}, 16'h000A);
        check("swap_depth", 16'(depth), 16'd1);
        cyc(1, 1, 1, 1, 4'hF, 1, 16'hFFFF, 3'd0);
        check("mid_rst_err", {15'h0, stack_err}, 16'h0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                1'($urandom),
                4'($urandom),
                $urandom_range(0, 3) == 0,
                16'($urandom),
                3'($urandom));
            if (failures > 50) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
